musa_muldiv18: RTL



---
 rtl/musa_muldiv18_pkg.sv | 22 ++
 rtl/musa_muldiv18.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/musa_muldiv18_pkg.sv
// Shared encodings and sizing for the MUSA multiply/divide unit.
package musa_pkg;

    localparam int MD_WIDTH = 18;
    localparam int MD_ITER  = 18;

    // op[0] selects divide, op[1] selects signed operands
    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_DIVU = 2'b01,
        OP_MUL  = 2'b10,
        OP_DIV  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/musa_muldiv18.sv
// Iterative 18-bit multiply/divide: shift-add multiply and restoring divide
// share one HI/LO working register pair; fixed 20-cycle latency.
module musa_muldiv18
    import musa_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W     = WIDTH;
    localparam int CNT_W = $clog2(MD_ITER);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fix_phase;   // FIX spends one cycle correcting, one writing back
    logic             r_is_div;
    logic             r_neg_lo;      // negate product / quotient
    logic             r_neg_hi;      // negate remainder (dividend sign)
    logic             r_div_zero;
    logic [W-1:0]     r_acc_hi;      // product high half / partial remainder
    logic [W-1:0]     r_acc_lo;      // multiplier shifting out / quotient shifting in
    logic [W-1:0]     r_opnd;        // multiplicand magnitude / divisor magnitude
    logic [W-1:0]     r_a_raw;       // raw dividend, returned on divide by zero

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [W:0]       w_add_sum;
    logic [W:0]       w_shift;
    logic             w_borrow;
    logic [W-1:0]     w_diff;

    // Operand magnitudes and one step of each algorithm
    always_comb begin
        w_a_neg   = op[1] & a[W-1];
        w_b_neg   = op[1] & b[W-1];
        w_a_mag   = w_a_neg ? -a : a;
        w_b_mag   = w_b_neg ? -b : b;
        w_add_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift   = {r_acc_hi, r_acc_lo[W-1]};
        w_borrow  = w_shift < {1'b0, r_opnd};
        w_diff    = w_shift[W-1:0] - r_opnd;
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(MD_ITER - 1)) w_state_nxt = FIX;
            end
            FIX: begin
                busy = 1'b1;
                if (r_fix_phase) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_accept    = start;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, correct and write back in FIX
    // NOTE: all datapath registers are plain flops (no memory), so each gets a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_fix_phase <= 1'b0;
            r_is_div    <= 1'b0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_div_zero  <= 1'b0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_opnd      <= '0;
            r_a_raw     <= '0;
            hi          <= '0;
            lo          <= '0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_fix_phase <= 1'b0;
            r_is_div    <= op[0];
            r_neg_lo    <= w_a_neg ^ w_b_neg;
            r_neg_hi    <= w_a_neg;
            r_div_zero  <= op[0] && (b == '0);
            r_acc_hi    <= '0;
            r_acc_lo    <= op[0] ? w_a_mag : w_b_mag;
            r_opnd      <= op[0] ? w_b_mag : w_a_mag;
            r_a_raw     <= a;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_acc_hi <= w_borrow ? w_shift[W-1:0] : w_diff;
                r_acc_lo <= {r_acc_lo[W-2:0], ~w_borrow};
            end else begin
                r_acc_hi <= w_add_sum[W:1];
                r_acc_lo <= {w_add_sum[0], r_acc_lo[W-1:1]};
            end
        end else if (r_state == FIX) begin
            r_fix_phase <= 1'b1;
            if (!r_fix_phase) begin
                if (!r_is_div) begin
                    if (r_neg_lo) {r_acc_hi, r_acc_lo} <= -{r_acc_hi, r_acc_lo};
                end else if (r_div_zero) begin
                    r_acc_hi <= r_a_raw;
                    r_acc_lo <= '1;
                end else begin
                    if (r_neg_lo) r_acc_lo <= -r_acc_lo;
                    if (r_neg_hi) r_acc_hi <= -r_acc_hi;
                end
            end else begin
                hi <= r_acc_hi;
                lo <= r_acc_lo;
            end
        end
    end

endmodule
